// File: rtl/uart_dbg_pkg.sv
// Shared constants and types for the UART debug word path.
package uart_dbg_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int DATA_WIDTH     = 32;
    localparam int FIFO_DEPTH     = 42;
    localparam int CNT_W          = 6;

    localparam int CLK_FREQ = 200000000;
    localparam int UART_BPS = 115200;

    // ~1 ms of silence, roughly 11 character times at the default rate
    localparam int TIMEOUT_CYCLES = CLK_FREQ / 1000;

    typedef logic [$clog2(BYTES_PER_WORD)-1:0] phase_t;

endpackage

// File: rtl/uart_byte_packer.sv
// Byte-event detect and little-endian packing of 4 bytes into one word.
// UART_WORD_TIMEOUT_EN adds an idle timeout that discards a partial word.
module uart_byte_packer
    import uart_dbg_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = uart_dbg_pkg::TIMEOUT_CYCLES
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  recv_done,
    input  logic [7:0]            recv_data,
    input  logic                  clear,
    output logic                  word_push,
    output logic [DATA_WIDTH-1:0] word,
    output logic [1:0]            byte_phase
);

    logic        done_q;
    phase_t      phase_q, phase_d;
    logic [23:0] pack_q, pack_d;
    logic        byte_evt;
    logic        resync;

    assign byte_evt   = recv_done && !done_q;
    assign word_push  = byte_evt && !clear && (phase_q == 2'd3);
    assign word       = {recv_data, pack_q};
    assign byte_phase = phase_q;

`ifdef UART_WORD_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [IDLE_W-1:0] idle_q, idle_d;

    always_comb begin
        idle_d = '0;
        resync = 1'b0;
        if (!clear && !byte_evt && phase_q != 2'd0) begin
            if (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1))
                resync = 1'b1;
            else
                idle_d = idle_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            idle_q <= '0;
        else
            idle_q <= idle_d;
    end
`else
    assign resync = 1'b0;
`endif

    always_comb begin
        phase_d = phase_q;
        pack_d  = pack_q;
        if (clear || resync) begin
            phase_d = '0;
            pack_d  = '0;
        end else if (byte_evt) begin
            unique case (phase_q)
                2'd0: pack_d[7:0]   = recv_data;
                2'd1: pack_d[15:8]  = recv_data;
                2'd2: pack_d[23:16] = recv_data;
                2'd3: pack_d        = '0;
            endcase
            phase_d = phase_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            done_q  <= 1'b0;
            phase_q <= '0;
            pack_q  <= '0;
        end else begin
            done_q  <= recv_done;
            phase_q <= phase_d;
            pack_q  <= pack_d;
        end
    end

endmodule

// File: rtl/uart_word_fifo.sv
// Packs received UART bytes into words and buffers them in a FWFT FIFO.
// Define UART_WORD_TIMEOUT_EN to drop stale partial words after an idle time.
module uart_word_fifo
    import uart_dbg_pkg::*;
#(
    parameter int DATA_WIDTH     = uart_dbg_pkg::DATA_WIDTH,
    parameter int FIFO_DEPTH     = uart_dbg_pkg::FIFO_DEPTH,
    parameter int CNT_W          = uart_dbg_pkg::CNT_W,
    parameter int TIMEOUT_CYCLES = uart_dbg_pkg::TIMEOUT_CYCLES
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  recv_done,
    input  logic [7:0]            recv_data,
    input  logic                  clear,
    output logic [DATA_WIDTH-1:0] word_data,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic [CNT_W-1:0]      fill_count,
    output logic                  full,
    output logic                  overflow,
    output logic [1:0]            byte_phase
);

    logic                  word_push;
    logic [DATA_WIDTH-1:0] push_word;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [CNT_W-1:0]      wr_q, wr_d;
    logic [CNT_W-1:0]      rd_q, rd_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic                  ovf_q, ovf_d;
    logic                  pop, push_ok, drop;

    function automatic logic [CNT_W-1:0] ptr_inc(input logic [CNT_W-1:0] p);
        return (p == CNT_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    uart_byte_packer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_packer (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .recv_done  (recv_done),
        .recv_data  (recv_data),
        .clear      (clear),
        .word_push  (word_push),
        .word       (push_word),
        .byte_phase (byte_phase)
    );

    assign word_valid = (cnt_q != '0);
    assign full       = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign fill_count = cnt_q;
    assign overflow   = ovf_q;
    assign word_data  = head_q;

    // A pop frees a slot, so a push into a full FIFO is kept in that cycle
    assign pop     = word_valid && word_ready && !clear;
    assign push_ok = word_push && (!full || pop);
    assign drop    = word_push && full && !pop;

    always_comb begin
        wr_d   = push_ok ? ptr_inc(wr_q) : wr_q;
        rd_d   = pop ? ptr_inc(rd_q) : rd_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q | drop;
        head_d = head_q;
        if (push_ok && !pop)
            cnt_d = cnt_q + 1'b1;
        else if (pop && !push_ok)
            cnt_d = cnt_q - 1'b1;
        // Head register follows the new read slot; a word landing there
        // must bypass the memory since it is written on the same edge.
        if (push_ok && wr_q == rd_d)
            head_d = push_word;
        else if (pop && cnt_q != CNT_W'(1))
            head_d = mem_q[rd_d];
        if (clear) begin
            wr_d   = '0;
            rd_d   = '0;
            cnt_d  = '0;
            ovf_d  = 1'b0;
            head_d = '0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push_ok)
            mem_q[wr_q] <= push_word;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            head_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            head_q <= head_d;
        end
    end

endmodule

// File: tb/tb_uart_word_fifo.sv
// Randomised and directed bench for uart_word_fifo against a queue model.
// Timeout checks are compiled in when UART_WORD_TIMEOUT_EN is defined.
module tb_uart_word_fifo;

    localparam int DEPTH = 42;
    localparam int TO    = 100;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        recv_done;
    logic [7:0]  recv_data;
    logic        clear;
    logic [31:0] word_data;
    logic        word_valid;
    logic        word_ready;
    logic [5:0]  fill_count;
    logic        full;
    logic        overflow;
    logic [1:0]  byte_phase;

    uart_word_fifo #(
        .DATA_WIDTH     (32),
        .FIFO_DEPTH     (DEPTH),
        .CNT_W          (6),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .recv_done  (recv_done),
        .recv_data  (recv_data),
        .clear      (clear),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .fill_count (fill_count),
        .full       (full),
        .overflow   (overflow),
        .byte_phase (byte_phase)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int fails  = 0;
    bit cmp_en = 1'b0;

    bit [31:0] mq[$];
    int        m_phase;
    bit [7:0]  m_bytes[4];
    bit        m_ovf;
    bit        m_prev;
    int        m_idle;

    bit [31:0] w3[43];
    bit [31:0] w4[92];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_phase = 0;
        m_ovf   = 1'b0;
        m_prev  = 1'b0;
        m_idle  = 0;
    endtask

    task automatic model_step(input bit d, input bit [7:0] data,
                              input bit clr, input bit rdy);
        bit ev;
        ev     = d && !m_prev;
        m_prev = d;
        if (clr) begin
            mq.delete();
            m_phase = 0;
            m_ovf   = 1'b0;
            m_idle  = 0;
            return;
        end
        if (rdy && mq.size() != 0)
            void'(mq.pop_front());
        if (ev) begin
            m_bytes[m_phase] = data;
            if (m_phase == 3) begin
                if (mq.size() < DEPTH)
                    mq.push_back({m_bytes[3], m_bytes[2],
                                  m_bytes[1], m_bytes[0]});
                else
                    m_ovf = 1'b1;
            end
            m_phase = (m_phase + 1) % 4;
            m_idle  = 0;
        end
`ifdef UART_WORD_TIMEOUT_EN
        else if (m_phase != 0) begin
            m_idle++;
            if (m_idle == TO) begin
                m_phase = 0;
                m_idle  = 0;
            end
        end
`endif
    endtask

    task automatic cycle(input bit d, input bit [7:0] data,
                         input bit clr, input bit rdy);
        recv_done  = d;
        recv_data  = data;
        clear      = clr;
        word_ready = rdy;
        @(posedge sys_clk);
        model_step(d, data, clr, rdy);
        #1;
    endtask

    task automatic send_byte(input bit [7:0] b, input int hold,
                             input bit rdy, input bit rdy_ev);
        cycle(1'b1, b, 1'b0, rdy_ev);
        for (int i = 1; i < hold; i++)
            cycle(1'b1, b, 1'b0, rdy);
        cycle(1'b0, b, 1'b0, rdy);
    endtask

    task automatic send_word(input bit [31:0] w, input int hold,
                             input bit rdy, input bit rdy_ev);
        for (int k = 0; k < 4; k++)
            send_byte(w[8*k +: 8], hold, rdy, (k == 3) ? rdy_ev : rdy);
    endtask

    always @(negedge sys_clk) begin
        if (cmp_en) begin
            chk("valid", word_valid, mq.size() != 0);
            chk("fill_count", fill_count, mq.size());
            chk("full", full, mq.size() == DEPTH);
            chk("overflow", overflow, m_ovf);
            chk("byte_phase", byte_phase, m_phase);
            if (mq.size() != 0)
                chk("word_data", word_data, mq[0]);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rst_n  = 1'b0;
        recv_done  = 1'b0;
        recv_data  = 8'h00;
        clear      = 1'b0;
        word_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("rst_valid", word_valid, 0);
        chk("rst_data", word_data, 0);
        chk("rst_fill", fill_count, 0);
        chk("rst_full", full, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_phase", byte_phase, 0);
        sys_rst_n = 1'b1;
        cmp_en    = 1'b1;

        // four single-cycle bytes, head appears right after 4th event edge
        send_byte(8'h11, 1, 1'b0, 1'b0);
        send_byte(8'h22, 1, 1'b0, 1'b0);
        send_byte(8'h33, 1, 1'b0, 1'b0);
        cycle(1'b1, 8'h44, 1'b0, 1'b0);
        chk("t1_valid", word_valid, 1);
        chk("t1_data", word_data, 32'h44332211);
        chk("t1_fill", fill_count, 1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t1_empty", word_valid, 0);

        // long recv_done pulses: one event each
        for (int i = 1; i <= 8; i++)
            send_byte(8'(i), 50, 1'b0, 1'b0);
        chk("t2_fill", fill_count, 2);
        chk("t2_phase", byte_phase, 0);
        chk("t2_w0", word_data, 32'h04030201);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t2_w1", word_data, 32'h08070605);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t2_empty", word_valid, 0);

        // overflow on the 43rd word, then in-order drain
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 43; i++) begin
            w3[i] = $urandom;
            send_word(w3[i], 1, 1'b0, 1'b0);
            if (i == 41) begin
                chk("t3_full", full, 1);
                chk("t3_noovf", overflow, 0);
            end
        end
        chk("t3_ovf", overflow, 1);
        chk("t3_fill", fill_count, DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            chk("t3_drain", word_data, w3[i]);
            cycle(1'b0, 8'h00, 1'b0, 1'b1);
        end
        chk("t3_empty", word_valid, 0);

        // full FIFO with simultaneous push/pop across pointer wrap
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 92; i++) begin
            w4[i] = $urandom;
            send_word(w4[i], 1, 1'b0, i >= DEPTH);
            if (i >= DEPTH - 1)
                chk("t4_fill", fill_count, DEPTH);
        end
        chk("t4_ovf", overflow, 0);
        chk("t4_head", word_data, w4[50]);
        for (int i = 0; i < DEPTH; i++)
            cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t4_empty", word_valid, 0);

        // clear discards a partial word and a same-cycle byte event
        send_byte(8'hAA, 1, 1'b0, 1'b0);
        send_byte(8'hBB, 1, 1'b0, 1'b0);
        cycle(1'b1, 8'h77, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t5_phase", byte_phase, 0);
        send_word(32'hDDCCBBAA, 1, 1'b0, 1'b0);
        chk("t5_data", word_data, 32'hDDCCBBAA);
        chk("t5_fill", fill_count, 1);
        chk("t5_ovf", overflow, 0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

`ifdef UART_WORD_TIMEOUT_EN
        send_byte(8'h55, 1, 1'b0, 1'b0);
        repeat (150) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t6_phase", byte_phase, 0);
        send_word(32'h04030201, 1, 1'b0, 1'b0);
        chk("t6_data", word_data, 32'h04030201);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
`endif

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 2) != 0, 8'($urandom),
                  $urandom_range(0, 299) == 0,
                  $urandom_range(0, 9) < ((i / 500) % 2 ? 2 : 7));
        end

        // asynchronous reset in the middle of a word
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        send_byte(8'h12, 1, 1'b0, 1'b0);
        send_byte(8'h34, 1, 1'b0, 1'b0);
        cmp_en = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        chk("t8_phase", byte_phase, 0);
        chk("t8_fill", fill_count, 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        model_reset();
        cmp_en = 1'b1;
        send_word(32'hCAFEF00D, 1, 1'b0, 1'b0);
        chk("t8_data", word_data, 32'hCAFEF00D);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
